bin_serializer: RTL and testbench

- Downstream of the part_mode binarizer (and other syntax-element binarizers).
- Accepts a packed bin string plus per-bin context/bypass information and buffers it in a small FIFO.
- Emits one bin per cycle to the CABAC arithmetic coding engine over a valid/ready handshake.
- Decouples single-cycle binarizer "done" pulses from the engine's variable acceptance rate.

---
 rtl/bin_serializer.sv | 198 +++++++++++++++++++
 tb/tb_bin_serializer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bin_serializer
// Purpose  : Buffers packed bin strings from the binarizers and emits them to
//            the CABAC engine one bin per cycle over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bin_serializer #(
   parameter int MAX_BIN = 4,
   parameter int LEN_W   = 3,
   parameter int CTX_W   = 8,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MAX_BIN-1:0] in_bin_string,
   input  logic [LEN_W-1:0]   in_bin_length,
   input  logic [MAX_BIN-1:0] in_bypass_mask,
   input  logic [CTX_W-1:0]   in_ctx_base,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_bin,
   output logic               out_bypass,
   output logic [CTX_W-1:0]   out_ctx_idx,
   output logic               out_first,
   output logic               out_last,
   output logic               busy,
   output logic               overflow,
   output logic               len_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
   localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_BIN);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [LEN_W-1:0]    idx_q, idx_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                overflow_q, overflow_d;
   logic                len_err_q, len_err_d;

   logic [MAX_BIN-1:0]  str_q  [DEPTH];
   logic [MAX_BIN-1:0]  str_d  [DEPTH];
   logic [LEN_W-1:0]    len_q  [DEPTH];
   logic [LEN_W-1:0]    len_d  [DEPTH];
   logic [MAX_BIN-1:0]  mask_q [DEPTH];
   logic [MAX_BIN-1:0]  mask_d [DEPTH];
   logic [CTX_W-1:0]    ctx_q  [DEPTH];
   logic [CTX_W-1:0]    ctx_d  [DEPTH];

   logic                w_push;
   logic                w_pop;
   logic [PTR_W-1:0]    w_nxt_ptr;
   logic [MAX_BIN-1:0]  w_head_str;
   logic [LEN_W-1:0]    w_head_len;
   logic [MAX_BIN-1:0]  w_head_mask;
   logic [CTX_W-1:0]    w_head_ctx;
   logic [LEN_W-1:0]    w_next_len;
   logic [LEN_W-1:0]    w_bit_idx;
   logic [MAX_BIN-1:0]  w_str_sh;
   logic [MAX_BIN-1:0]  w_mask_sh;
   logic                w_is_last;

   // Head entry stays in the FIFO while its bins are sent; it is popped on the
   // final handshake, so the output fields are read straight from storage.
   always_comb begin
      w_head_str  = str_q[rd_ptr_q];
      w_head_len  = len_q[rd_ptr_q];
      w_head_mask = mask_q[rd_ptr_q];
      w_head_ctx  = ctx_q[rd_ptr_q];
      w_nxt_ptr   = rd_ptr_q + PTR_W'(1);
      w_next_len  = len_q[w_nxt_ptr];
      w_bit_idx   = w_head_len - LEN_W'(1) - idx_q;
      w_str_sh    = w_head_str >> w_bit_idx;
      w_mask_sh   = w_head_mask >> idx_q;
      w_is_last   = (idx_q == (w_head_len - LEN_W'(1)));

      in_ready    = (count_q < c_depth);
      out_valid   = (state_q == ST_SEND);
      out_bin     = out_valid & w_str_sh[0];
      out_bypass  = out_valid & w_mask_sh[0];
      out_ctx_idx = out_valid ? (w_head_ctx + CTX_W'(idx_q)) : '0;
      out_first   = out_valid && (idx_q == '0);
      out_last    = out_valid && w_is_last;
      busy        = (count_q != '0) || out_valid;
      overflow    = overflow_q;
      len_err     = len_err_q;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      w_pop   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               if (w_head_len == '0) begin
                  w_pop = 1'b1;
               end else begin
                  state_d = ST_SEND;
                  idx_d   = '0;
               end
            end
         end
         ST_SEND: begin
            if (out_ready) begin
               if (w_is_last) begin
                  w_pop = 1'b1;
                  idx_d = '0;
                  // Chain straight into an already-buffered string to avoid a bubble.
                  if ((count_q > CNT_W'(1)) && (w_next_len != '0)) begin
                     state_d = ST_SEND;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  idx_d = idx_q + LEN_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_comb begin
      w_push     = in_valid && in_ready;
      str_d      = str_q;
      len_d      = len_q;
      mask_d     = mask_q;
      ctx_d      = ctx_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (in_valid & ~in_ready);
      len_err_d  = len_err_q | (w_push & (in_bin_length > c_max_len));

      if (w_push) begin
         str_d[wr_ptr_q]  = in_bin_string;
         len_d[wr_ptr_q]  = (in_bin_length > c_max_len) ? c_max_len : in_bin_length;
         mask_d[wr_ptr_q] = in_bypass_mask;
         ctx_d[wr_ptr_q]  = in_ctx_base;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
         rd_ptr_d = w_nxt_ptr;
      end
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         len_err_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            str_q[i]  <= '0;
            len_q[i]  <= '0;
            mask_q[i] <= '0;
            ctx_q[i]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         len_err_q  <= len_err_d;
         str_q      <= str_d;
         len_q      <= len_d;
         mask_q     <= mask_d;
         ctx_q      <= ctx_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bin_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_serializer
// Purpose  : Directed scoreboard bench for bin_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_bin_string;
   logic [2:0] in_bin_length;
   logic [3:0] in_bypass_mask;
   logic [7:0] in_ctx_base;
   logic       out_valid;
   logic       out_ready;
   logic       out_bin;
   logic       out_bypass;
   logic [7:0] out_ctx_idx;
   logic       out_first;
   logic       out_last;
   logic       busy;
   logic       overflow;
   logic       len_err;

   typedef struct packed {
      logic       bin;
      logic       byp;
      logic [7:0] ctx;
      logic       first;
      logic       last;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_hs     = 0;

   bin_serializer #(.MAX_BIN(4), .LEN_W(3), .CTX_W(8), .DEPTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_bin_string (in_bin_string),
      .in_bin_length (in_bin_length),
      .in_bypass_mask(in_bypass_mask),
      .in_ctx_base   (in_ctx_base),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_bin       (out_bin),
      .out_bypass    (out_bypass),
      .out_ctx_idx   (out_ctx_idx),
      .out_first     (out_first),
      .out_last      (out_last),
      .busy          (busy),
      .overflow      (overflow),
      .len_err       (len_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic exp(input bit b, input bit y, input int c, input bit f, input bit l);
      exp_t e;
      e.bin   = b;
      e.byp   = y;
      e.ctx   = c[7:0];
      e.first = f;
      e.last  = l;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [3:0] s, input logic [2:0] len,
                       input logic [3:0] m, input logic [7:0] c);
      in_valid       = 1'b1;
      in_bin_string  = s;
      in_bin_length  = len;
      in_bypass_mask = m;
      in_ctx_base    = c;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) done = 1;
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s: drain timeout, busy=%0b pending=%0d", name, busy, exp_q.size());
      end
   endtask

   // Scoreboard monitor: one pop/compare per accepted bin.
   initial begin
      exp_t got;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            got = {out_bin, out_bypass, out_ctx_idx, out_first, out_last};
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_bin: got %0h expected none", got);
            end else begin
               e = exp_q.pop_front();
               chk("bin_stream", got, e);
            end
            n_hs++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      int guard;
      rst            = 1'b1;
      in_valid       = 1'b0;
      in_bin_string  = '0;
      in_bin_length  = '0;
      in_bypass_mask = '0;
      in_ctx_base    = '0;
      out_ready      = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_busy",      busy,      0);
      chk("rst_overflow",  overflow,  0);
      chk("rst_len_err",   len_err,   0);

      // Single string with latency check
      @(posedge clk); #1 out_ready = 1'b1;
      exp(0, 0, 10, 1, 0);
      exp(1, 0, 11, 0, 0);
      exp(1, 1, 12, 0, 1);
      send(4'b0011, 3'd3, 4'b0100, 8'd10);
      @(negedge clk);
      chk("latency_edge_n", out_valid, 0);
      @(negedge clk);
      chk("latency_edge_n1", out_valid, 1);
      wait_idle("single_drain");

      // Back-to-back strings without a bubble
      exp(1, 0, 20, 1, 1);
      exp(0, 0, 30, 1, 0);
      exp(0, 0, 31, 0, 0);
      exp(0, 0, 32, 0, 0);
      exp(1, 0, 33, 0, 1);
      send(4'b0001, 3'd1, 4'b0000, 8'd20);
      send(4'b0001, 3'd4, 4'b0000, 8'd30);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_bubble", out_valid, 1);
      end
      wait_idle("b2b_drain");

      // Backpressure, FIFO full and overflow
      @(posedge clk); #1 out_ready = 1'b0;
      exp(1, 1, 40, 1, 0);
      exp(0, 0, 41, 0, 1);
      exp(0, 0, 50, 1, 0);
      exp(1, 0, 51, 0, 1);
      send(4'b0010, 3'd2, 4'b0001, 8'd40);
      send(4'b0001, 3'd2, 4'b0000, 8'd50);
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      send(4'b1111, 3'd4, 4'b1111, 8'd60);
      @(negedge clk);
      chk("overflow_set", overflow, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_bin",   out_bin,   1);
         chk("hold_ctx",   out_ctx_idx, 40);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      wait_idle("bp_drain");

      // Zero length then clamped length
      chk("len_err_before", len_err, 0);
      exp(1, 1, 80, 1, 0);
      exp(0, 1, 81, 0, 0);
      exp(1, 0, 82, 0, 0);
      exp(0, 0, 83, 0, 1);
      send(4'b1111, 3'd0, 4'b1111, 8'd70);
      send(4'b1010, 3'd6, 4'b0011, 8'd80);
      @(negedge clk);
      chk("len_err_set", len_err, 1);
      wait_idle("edge_len_drain");

      // Context index wrap
      exp(1, 0, 254, 1, 0);
      exp(0, 0, 255, 0, 0);
      exp(1, 0, 0,   0, 1);
      send(4'b0101, 3'd3, 4'b0000, 8'd254);
      wait_idle("ctx_wrap_drain");

      // Reset after bin 1 of a 4-bin string
      start = n_hs;
      exp(1, 1, 100, 1, 0);
      exp(0, 1, 101, 0, 0);
      exp(0, 1, 102, 0, 0);
      exp(1, 1, 103, 0, 1);
      send(4'b1001, 3'd4, 4'b1111, 8'd100);
      guard = 0;
      while (n_hs < start + 2 && guard < 50) begin
         @(posedge clk);
         guard++;
      end
      chk("mid_reset_reach", (n_hs >= start + 2), 1);
      #1 rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_busy",      busy,      0);
      chk("mrst_overflow",  overflow,  0);
      chk("mrst_len_err",   len_err,   0);
      chk("mrst_in_ready",  in_ready,  1);
      exp(1, 0, 5, 1, 0);
      exp(0, 0, 6, 0, 1);
      send(4'b0010, 3'd2, 4'b0000, 8'd5);
      wait_idle("post_reset_drain");

      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
